// File: rtl/pulse_sequencer_multi.sv
// pulse_sequencer_multi: register-programmed pulse transmitter. Plays a range of
// symbols from local memory; each symbol picks a level (its MSB) and a duration
// (lookup table). Supports finite/infinite looping, abort, carrier gating,
// status readback and a level completion interrupt.
module pulse_sequencer_multi #(
    parameter int SYM_BITS  = 2,
    parameter int DUR_W     = 8,
    parameter int MEM_WORDS = 4,
    parameter int CARRIER_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        pulse_out,
    output logic        carrier_out,
    output logic        busy,
    output logic        irq
);
    localparam int SPW    = 32 / SYM_BITS;
    localparam int SPW_LG = $clog2(SPW);
    localparam int PC_W   = $clog2(MEM_WORDS * SPW);
    localparam int NDUR   = 1 << SYM_BITS;
    localparam int WI_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t               state_q, state_d;

    // Programming registers
    logic                 idle_level_q, invert_q, carrier_en_q, irq_en_q;
    logic [7:0]           pre_q;
    logic [31:0]          prog_q;
    logic [15:0]          loop_q;
    logic [CARRIER_W-1:0] half_q;
    logic                 done_q;

    // Sequencer state
    logic [PC_W-1:0]      pc_q;
    logic [15:0]          loops_q;
    logic                 level_q;
    logic [DUR_W-1:0]     dur_q;
    logic [7:0]           presc_q;
    logic                 nlev_q;
    logic [DUR_W-1:0]     ndur_q;
    logic                 pf_vld_q;
    logic [CARRIER_W-1:0] ccnt_q;
    logic                 carrier_q;

    // Storage (not reset)
    logic [31:0]          sym_mem [MEM_WORDS];
    logic [DUR_W-1:0]     dur_mem [NDUR];

    // Extract symbol idx from the memory word that holds it
    function automatic logic [SYM_BITS-1:0] pick_sym(input logic [31:0] word,
                                                     input logic [PC_W-1:0] idx);
        logic [4:0] bo;
        bo = 5'(idx[SPW_LG-1:0]) * 5'(SYM_BITS);
        return SYM_BITS'(word >> bo);
    endfunction

    // Register decode
    logic            wr_ctrl, start_w, stop_w, w1c_done;
    logic [4:0]      a_lo;
    logic            dur_hit, mem_hit;

    assign wr_ctrl  = wr_en && (addr == 6'h00);
    assign start_w  = wr_ctrl && wr_data[0];
    assign stop_w   = wr_ctrl && wr_data[1];
    assign w1c_done = wr_en && (addr == 6'h04) && wr_data[1];
    assign a_lo     = {1'b0, addr[3:0]};
    assign dur_hit  = (addr[5:4] == 2'b01) && (a_lo < 5'(NDUR));
    assign mem_hit  = (addr[5:4] == 2'b10) && (a_lo < 5'(MEM_WORDS));

    // Symbol fetch: current pc (for LOAD) and next pc (prefetch / apply)
    logic [PC_W-1:0]     start_pc, end_pc, next_pc;
    logic [SYM_BITS-1:0] cur_sym, nxt_sym;
    logic                apply_lev;
    logic [DUR_W-1:0]    apply_dur;
    logic                at_end, tick, expire, finish;

    assign start_pc  = prog_q[PC_W-1:0];
    assign end_pc    = prog_q[16 +: PC_W];
    assign at_end    = (pc_q == end_pc);
    // Wraps modulo 2^PC_W, so end_idx below start_idx is legal
    assign next_pc   = at_end ? start_pc : pc_q + PC_W'(1);
    assign cur_sym   = pick_sym(sym_mem[WI_W'(pc_q >> SPW_LG)], pc_q);
    assign nxt_sym   = pick_sym(sym_mem[WI_W'(next_pc >> SPW_LG)], next_pc);
    // A one-cycle symbol has no spare cycle to prefetch, so fall back to a direct fetch
    assign apply_lev = pf_vld_q ? nlev_q : nxt_sym[SYM_BITS-1];
    assign apply_dur = pf_vld_q ? ndur_q : dur_mem[nxt_sym];
    assign tick      = (presc_q == 8'd0);
    assign expire    = (state_q == S_RUN) && tick && (dur_q == '0);
    assign finish    = expire && at_end && (loops_q == 16'd1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: stop beats start and aborts from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_w && !stop_w) state_d = S_LOAD;
            S_LOAD:  state_d = stop_w ? S_IDLE : S_RUN;
            S_RUN:   if (stop_w || finish) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: output mux, raw carrier gate and interrupt level
    always_comb begin
        busy        = (state_q != S_IDLE);
        carrier_out = busy & carrier_q;
        if (busy) pulse_out = (level_q & (carrier_en_q ? carrier_q : 1'b1)) ^ invert_q;
        else      pulse_out = idle_level_q ^ invert_q;
        irq         = done_q & irq_en_q;
    end

    // Programming registers and sticky done (a completion beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_level_q <= 1'b0;
            invert_q     <= 1'b0;
            carrier_en_q <= 1'b0;
            irq_en_q     <= 1'b0;
            pre_q        <= 8'd0;
            prog_q       <= 32'd0;
            loop_q       <= 16'd0;
            half_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                idle_level_q <= wr_data[2];
                invert_q     <= wr_data[3];
                carrier_en_q <= wr_data[4];
                irq_en_q     <= wr_data[5];
                pre_q        <= wr_data[15:8];
            end
            if (wr_en && addr == 6'h01) prog_q <= wr_data;
            if (wr_en && addr == 6'h02) loop_q <= wr_data[15:0];
            if (wr_en && addr == 6'h03) half_q <= wr_data[CARRIER_W-1:0];
            if (finish)        done_q <= 1'b1;
            else if (w1c_done) done_q <= 1'b0;
        end
    end

    // Symbol and duration storage writes
    always_ff @(posedge clk) begin
        if (wr_en && dur_hit) dur_mem[addr[SYM_BITS-1:0]] <= wr_data[DUR_W-1:0];
        if (wr_en && mem_hit) sym_mem[WI_W'(addr[3:0])]  <= wr_data;
    end

    // Sequencer datapath: pc/loop bookkeeping, prescaled duration count, prefetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            loops_q  <= 16'd0;
            level_q  <= 1'b0;
            dur_q    <= '0;
            presc_q  <= 8'd0;
            nlev_q   <= 1'b0;
            ndur_q   <= '0;
            pf_vld_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_LOAD) begin
                        pc_q    <= start_pc;
                        loops_q <= loop_q;
                        level_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    level_q  <= cur_sym[SYM_BITS-1];
                    dur_q    <= dur_mem[cur_sym];
                    presc_q  <= pre_q;
                    pf_vld_q <= 1'b0;
                end
                S_RUN: begin
                    if (expire) begin
                        level_q  <= apply_lev;
                        dur_q    <= apply_dur;
                        presc_q  <= pre_q;
                        pc_q     <= next_pc;
                        pf_vld_q <= 1'b0;
                        if (at_end && loops_q > 16'd1) loops_q <= loops_q - 16'd1;
                    end else begin
                        if (tick) begin
                            presc_q <= pre_q;
                            dur_q   <= dur_q - DUR_W'(1);
                        end else begin
                            presc_q <= presc_q - 8'd1;
                        end
                        if (!pf_vld_q) begin
                            nlev_q   <= nxt_sym[SYM_BITS-1];
                            ndur_q   <= dur_mem[nxt_sym];
                            pf_vld_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Carrier: cleared outside RUN-bound cycles, toggles every H+1 cycles otherwise
    always_ff @(posedge clk) begin
        if (rst || state_d != S_RUN) begin
            ccnt_q    <= '0;
            carrier_q <= 1'b0;
        end else if (ccnt_q == '0) begin
            ccnt_q    <= half_q;
            carrier_q <= ~carrier_q;
        end else begin
            ccnt_q    <= ccnt_q - CARRIER_W'(1);
        end
    end

    // Combinational register readback
    always_comb begin
        rd_data = 32'd0;
        if (addr == 6'h00)
            rd_data = {16'd0, pre_q, 2'b00, irq_en_q, carrier_en_q, invert_q, idle_level_q, 2'b00};
        else if (addr == 6'h01)
            rd_data = prog_q;
        else if (addr == 6'h02)
            rd_data = {16'd0, loop_q};
        else if (addr == 6'h03)
            rd_data = 32'(half_q);
        else if (addr == 6'h04)
            rd_data = {loops_q, 8'(pc_q), 6'd0, done_q, busy};
        else if (dur_hit)
            rd_data = 32'(dur_mem[addr[SYM_BITS-1:0]]);
        else if (mem_hit)
            rd_data = sym_mem[WI_W'(addr[3:0])];
    end

endmodule

// File: tb/tb_pulse_sequencer_multi.sv
// Testbench for pulse_sequencer_multi: register table, directed corner cases and
// randomized sequences against a cycle-list reference model.
module tb_pulse_sequencer_multi;
    logic        clk = 1'b0;
    logic        rst, wr_en;
    logic [5:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        pulse_out, carrier_out, busy, irq;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    pulse_sequencer_multi dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .pulse_out(pulse_out), .carrier_out(carrier_out),
        .busy(busy), .irq(irq)
    );

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t vt[13];

    int exp_basic[14] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1};
    int exp_car[8]    = '{1,1,0,0,1,1,0,0};
    int exp_inf[5]    = '{1,1,1,0,0};
    int pcs_loop[3]   = '{63,0,1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        addr    = 6'h04;
        wr_data = 32'd0;
    endtask

    task automatic set_dur(input int d0, input int d1, input int d2, input int d3);
        wr(6'h10, 32'(d0));
        wr(6'h11, 32'(d1));
        wr(6'h12, 32'(d2));
        wr(6'h13, 32'(d3));
    endtask

    // Random-test state
    int          rdur[4];
    logic [31:0] rword[4];
    int          lvq[$];

    initial begin
        rst = 1'b1; wr_en = 1'b0; addr = 6'h00; wr_data = 32'd0;
        vt[0]  = '{6'h00, 32'hFFFF_FFFE, 32'h0000_FF3C};
        vt[1]  = '{6'h01, 32'h1234_5678, 32'h1234_5678};
        vt[2]  = '{6'h02, 32'hABCD_9876, 32'h0000_9876};
        vt[3]  = '{6'h03, 32'h5555_AAAA, 32'h0000_AAAA};
        vt[4]  = '{6'h10, 32'hFFFF_FF5A, 32'h0000_005A};
        vt[5]  = '{6'h13, 32'h0000_0107, 32'h0000_0007};
        vt[6]  = '{6'h14, 32'h0000_00FF, 32'h0000_0000};
        vt[7]  = '{6'h21, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[8]  = '{6'h24, 32'h1111_1111, 32'h0000_0000};
        vt[9]  = '{6'h05, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[10] = '{6'h3F, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[11] = '{6'h04, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[12] = '{6'h00, 32'h0000_0000, 32'h0000_0000};

        // Reset state
        step(); step();
        rst = 1'b0;
        addr = 6'h04; #1;
        chk("reset_pulse", 32'(pulse_out), 0);
        chk("reset_carrier", 32'(carrier_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_status", rd_data, 0);
        step();

        // Register map table
        for (int i = 0; i < 13; i++) begin
            wr(vt[i].a, vt[i].d);
            addr = vt[i].a; #1;
            chk($sformatf("regmap_%0h", vt[i].a), rd_data, vt[i].e);
            chk("regmap_idle", 32'(busy), 0);
        end
        step();

        // Basic sequence: low 3, low 5, high 2, high 4
        set_dur(2, 4, 1, 3);
        wr(6'h20, 32'h0000_00E4);
        wr(6'h01, 32'h0003_0000);
        wr(6'h02, 32'd1);
        wr(6'h00, 32'h21);
        chk("basic_load_busy", 32'(busy), 1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("basic_pulse_%0d", i), 32'(pulse_out), 32'(exp_basic[i]));
            chk($sformatf("basic_busy_%0d", i), 32'(busy), 1);
        end
        step();
        chk("basic_busy_end", 32'(busy), 0);
        chk("basic_pulse_idle", 32'(pulse_out), 0);
        chk("basic_done", 32'(rd_data[1]), 1);
        chk("basic_irq", 32'(irq), 1);
        wr(6'h04, 32'h2);
        chk("basic_w1c_done", 32'(rd_data[1]), 0);
        chk("basic_w1c_irq", 32'(irq), 0);

        // Done W1C race: clear lands on the cycle done sets
        wr(6'h00, 32'h21);
        for (int i = 0; i < 14; i++) step();
        chk("race_busy_last", 32'(busy), 1);
        wr(6'h04, 32'h2);
        chk("race_busy", 32'(busy), 0);
        chk("race_done_kept", 32'(rd_data[1]), 1);
        wr(6'h04, 32'h2);
        chk("race_cleared", 32'(rd_data[1]), 0);

        // Looping and wrap: pc 63,0,1,63,0,1 with loops 2 then 1
        set_dur(1, 1, 1, 1);
        wr(6'h23, 32'hC000_0000);
        wr(6'h01, 32'h0001_003F);
        wr(6'h02, 32'd2);
        wr(6'h00, 32'h01);
        for (int j = 0; j < 12; j++) begin
            step();
            chk($sformatf("loop_pc_%0d", j), 32'(rd_data[15:8]), 32'(pcs_loop[(j / 2) % 3]));
            chk($sformatf("loop_cnt_%0d", j), 32'(rd_data[31:16]), (j < 6) ? 32'd2 : 32'd1);
            chk($sformatf("loop_pulse_%0d", j), 32'(pulse_out), (pcs_loop[(j / 2) % 3] == 63) ? 32'd1 : 32'd0);
        end
        step();
        chk("loop_busy_end", 32'(busy), 0);
        chk("loop_done", 32'(rd_data[1]), 1);
        wr(6'h04, 32'h2);

        // Prescaler and carrier: pre=3, D=1, H=1
        set_dur(0, 0, 1, 0);
        wr(6'h20, 32'h2);
        wr(6'h01, 32'h0000_0000);
        wr(6'h02, 32'd1);
        wr(6'h03, 32'd1);
        wr(6'h00, 32'h311);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("car_pulse_%0d", i), 32'(pulse_out), 32'(exp_car[i]));
            chk($sformatf("car_raw_%0d", i), 32'(carrier_out), 32'(exp_car[i]));
            chk($sformatf("car_busy_%0d", i), 32'(busy), 1);
        end
        step();
        chk("car_busy_end", 32'(busy), 0);
        chk("car_raw_idle", 32'(carrier_out), 0);
        wr(6'h00, 32'h08);
        chk("invert_idle", 32'(pulse_out), 1);
        wr(6'h00, 32'h00);
        wr(6'h04, 32'h2);

        // Abort at cycle 5 of a 20-cycle symbol
        set_dur(0, 0, 0, 19);
        wr(6'h20, 32'h3);
        wr(6'h00, 32'h01);
        for (int i = 0; i < 5; i++) step();
        chk("abort_pre_busy", 32'(busy), 1);
        chk("abort_pre_pulse", 32'(pulse_out), 1);
        wr(6'h00, 32'h02);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pulse", 32'(pulse_out), 0);
        chk("abort_done", 32'(rd_data[1]), 0);
        for (int i = 0; i < 3; i++) step();
        chk("abort_done_later", 32'(rd_data[1]), 0);
        wr(6'h00, 32'h03);
        chk("startstop_busy", 32'(busy), 0);
        step();
        chk("startstop_busy2", 32'(busy), 0);

        // Infinite mode: 3 passes of H H H L L, then reset mid-run
        set_dur(1, 0, 2, 0);
        wr(6'h20, 32'h2);
        wr(6'h01, 32'h0001_0000);
        wr(6'h02, 32'd0);
        wr(6'h00, 32'h05);
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("inf_pulse_%0d", i), 32'(pulse_out), 32'(exp_inf[i % 5]));
            chk($sformatf("inf_busy_%0d", i), 32'(busy), 1);
        end
        chk("inf_done", 32'(rd_data[1]), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pulse", 32'(pulse_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_carrier", 32'(carrier_out), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_status", rd_data, 0);
        addr = 6'h01; #1;
        chk("rst_prog", rd_data, 0);
        addr = 6'h00; #1;
        chk("rst_ctrl", rd_data, 0);
        step();

        // Randomized sequences against the reference model
        for (int t = 0; t < 20; t++) begin
            int pre, h, cen, inv, idl, s, e, loops, idx, sym, len, cfg, car, ex;
            bit pass_done;
            for (int k = 0; k < 4; k++) begin
                rdur[k]  = $urandom_range(0, 5);
                rword[k] = $urandom;
                wr(6'(16 + k), 32'(rdur[k]));
                wr(6'(32 + k), rword[k]);
            end
            pre   = $urandom_range(0, 2);
            h     = $urandom_range(0, 3);
            cen   = $urandom_range(0, 1);
            inv   = $urandom_range(0, 1);
            idl   = $urandom_range(0, 1);
            s     = $urandom_range(0, 63);
            e     = (s + $urandom_range(0, 5)) % 64;
            loops = $urandom_range(1, 2);
            wr(6'h01, 32'((e << 16) | s));
            wr(6'h02, 32'(loops));
            wr(6'h03, 32'(h));
            cfg = (idl << 2) | (inv << 3) | (cen << 4) | (pre << 8);
            wr(6'h00, 32'(cfg));
            chk($sformatf("rnd%0d_idle", t), 32'(pulse_out), 32'(idl ^ inv));

            lvq.delete();
            for (int l = 0; l < loops; l++) begin
                idx = s;
                pass_done = 1'b0;
                while (!pass_done) begin
                    sym = int'((rword[idx / 16] >> (2 * (idx % 16))) & 32'h3);
                    len = (rdur[sym] + 1) * (pre + 1);
                    for (int c = 0; c < len; c++) lvq.push_back(sym >> 1);
                    if (idx == e) pass_done = 1'b1;
                    else idx = (idx + 1) % 64;
                end
            end

            wr(6'h00, 32'(cfg | 1));
            for (int n = 1; n <= lvq.size(); n++) begin
                step();
                car = ((n + h) / (h + 1)) % 2;
                ex  = (lvq[n - 1] & (cen != 0 ? car : 1)) ^ inv;
                chk($sformatf("rnd%0d_pulse_%0d", t, n), 32'(pulse_out), 32'(ex));
                chk($sformatf("rnd%0d_car_%0d", t, n), 32'(carrier_out), 32'(car));
                chk($sformatf("rnd%0d_busy_%0d", t, n), 32'(busy), 1);
            end
            step();
            chk($sformatf("rnd%0d_end_busy", t), 32'(busy), 0);
            chk($sformatf("rnd%0d_end_pulse", t), 32'(pulse_out), 32'(idl ^ inv));
            chk($sformatf("rnd%0d_end_done", t), 32'(rd_data[1]), 1);
            wr(6'h04, 32'h2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
